watch_ctrl: RTL and testbench
=============================

Name: watch_ctrl

Overview:
- Mode/setting controller that sequences the watch datapath (watch_top): generates its run enable and a one-cycle time-load strobe with user-edited hour/min/sec values.
- Consumes debounced single-cycle button pulses and the datapath's current time; drives a blink flag for the digit under edit.
- Sits between the button front-end and watch_top, sharing the watch's i_freq clock-frequency word.

Parameters:
- P_COUNT_BIT, 30, width of i_freq and internal prescaler (clock below 1 GHz)
- P_SEC_BIT, 6, seconds field width
- P_MIN_BIT, 6, minutes field width
- P_HOUR_BIT, 5, hours field width
- P_TIMEOUT_SEC, 10, edit-mode inactivity timeout in seconds (1..63)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- i_freq  in  P_COUNT_BIT  clk frequency in Hz, sampled every cycle
- i_btn_start  in  1  start/stop pulse
- i_btn_mode  in  1  mode/next-field pulse
- i_btn_up  in  1  increment pulse
- i_btn_down  in  1  decrement pulse
- i_sec, i_min, i_hour  in  field widths  current time from datapath
- o_run_en  out  1  run enable to datapath
- o_load  out  1  one-cycle load strobe to datapath
- o_load_sec, o_load_min, o_load_hour  out  field widths  edited values, valid when o_load=1
- o_edit_sel  out  2  0 none, 1 hour, 2 min, 3 sec
- o_blink  out  1  blink phase for selected field

Behaviour:
- Clock is clk; reset is synchronous, active-low. Reset wins over all inputs. Reset values: state STOP, all outputs 0, edit registers 0, prescaler and timeout counters 0.
- States: STOP, RUN, EDIT_H, EDIT_M, EDIT_S, COMMIT. All outputs are registered; an event at edge N is visible after edge N.
- Button priority per cycle: start > mode > up/down. If up and down are both high, the field is unchanged.
- STOP:
  - start -> RUN, o_run_en=1.
  - mode -> EDIT_H; capture i_hour/i_min/i_sec into edit registers on the same edge.
- RUN:
  - start -> STOP, o_run_en=0.
  - mode -> EDIT_H with capture, o_run_en=0.
- EDIT_H:
  - up: +1 mod 24 (23->0); down: -1 (0->23).
  - mode -> EDIT_M.
- EDIT_M and EDIT_S:
  - up/down mod 60 (59<->0).
  - EDIT_M mode -> EDIT_S; EDIT_S mode -> COMMIT.
- Captured values out of range (hour>23, min/sec>59) are clamped to 0 at capture.
- COMMIT: lasts exactly 1 cycle with o_load=1 and o_load_* = edit registers; then -> STOP, o_run_en=0.
- start in any EDIT state aborts: -> STOP, no o_load, edit registers retained.
- o_edit_sel: 1/2/3 in EDIT_H/M/S, otherwise 0.
- Blink prescaler:
  - half = i_freq>>1; counter 0..half-1. On wrap, emit half-tick and toggle o_blink.
  - If half==0, tick every cycle.
  - Counter and o_blink reset to 0 when entering EDIT_H and on any up/down press.
  - o_blink is forced to 0 outside EDIT states.
  - A change of i_freq mid-count: if counter >= new half-1, wrap on the next cycle.
- Timeout:
  - Counts half-ticks in EDIT states; cleared by any button press and on EDIT entry.
  - At 2*P_TIMEOUT_SEC half-ticks: abort -> STOP, no load.
- o_load is never asserted outside COMMIT. o_run_en never changes during COMMIT.

Decomposition:
- Package watch_pkg holds:
  - state enum;
  - constants HOURS_PER_DAY=24, MIN_PER_HOUR=60, SEC_PER_MIN=60;
  - edit_sel encodings;
  - default field widths.
- One sub-module, watch_half_tick_gen: prescaler with clear input, producing the half-second tick and blink toggle. Shared later with the display blink logic.

Test Plan:
- Reset (reset=0 for 3 cycles, all buttons high) -> o_run_en=0, o_load=0, o_edit_sel=0, o_blink=0. Release, pulse start -> o_run_en=1 next cycle.
- In RUN with i_hour=23, i_min=59, i_sec=58: pulse mode -> o_run_en=0, o_edit_sel=1. Then:
  - up -> hour 0;
  - mode, down x60 -> min 59;
  - mode, up x2 -> sec 0;
  - mode -> one-cycle o_load with 0/59/0, then STOP.
- Simultaneous inputs in EDIT_M (min=0): up+down together -> min 0; mode+up together -> EDIT_S, min unchanged; start+mode together -> STOP, no o_load.
- i_freq=10 in EDIT_H: o_blink toggles every 5 cycles. An up press resets the phase to o_blink=0 for 5 cycles. i_freq=1 -> toggles every cycle.
- P_TIMEOUT_SEC=2, i_freq=10, no buttons after entering EDIT_H -> abort to STOP exactly 20 cycles after entry, no o_load.
- reset asserted during COMMIT cycle and mid-EDIT_S -> next cycle STOP, o_load=0, edit registers 0, no load strobe after release.

Source files
------------

// File: rtl/watch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : watch_pkg                                                    |
// | Description : Shared types and constants for the watch mode/setting        |
// |               controller: state encoding, time-field moduli, edit-select   |
// |               codes, default field widths and small field helpers.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package watch_pkg;

   typedef enum logic [2:0] {
      ST_STOP   = 3'd0,
      ST_RUN    = 3'd1,
      ST_EDIT_H = 3'd2,
      ST_EDIT_M = 3'd3,
      ST_EDIT_S = 3'd4,
      ST_COMMIT = 3'd5
   } state_t;

   localparam int HOURS_PER_DAY = 24;
   localparam int MIN_PER_HOUR  = 60;
   localparam int SEC_PER_MIN   = 60;

   localparam logic [1:0] SEL_NONE = 2'd0;
   localparam logic [1:0] SEL_HOUR = 2'd1;
   localparam logic [1:0] SEL_MIN  = 2'd2;
   localparam logic [1:0] SEL_SEC  = 2'd3;

   localparam int DEF_COUNT_BIT = 30;
   localparam int DEF_SEC_BIT   = 6;
   localparam int DEF_MIN_BIT   = 6;
   localparam int DEF_HOUR_BIT  = 5;

   function automatic logic is_edit(input state_t s);
      return (s == ST_EDIT_H) || (s == ST_EDIT_M) || (s == ST_EDIT_S);
   endfunction

   function automatic logic [1:0] edit_sel_of(input state_t s);
      case (s)
         ST_EDIT_H: return SEL_HOUR;
         ST_EDIT_M: return SEL_MIN;
         ST_EDIT_S: return SEL_SEC;
         default:   return SEL_NONE;
      endcase
   endfunction

   // Out-of-range captured values restart at zero rather than saturating.
   function automatic int clamp_field(input int val, input int modulus);
      return (val >= modulus) ? 0 : val;
   endfunction

   // One wrap-around step of a field; callers guarantee val < modulus.
   function automatic int step_field(input int val, input int modulus, input logic up);
      if (up) begin
         return (val == modulus - 1) ? 0 : val + 1;
      end
      return (val == 0) ? modulus - 1 : val - 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/watch_half_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : watch_half_tick_gen                                          |
// | Description : Half-second prescaler. Counts 0..(freq/2)-1 and on wrap      |
// |               raises tick and toggles blink. clear restarts the phase.     |
// | Ports       : clk, reset (sync, active-low), freq (clk rate in Hz),        |
// |               clear (restart phase, blink=0), tick (wrap this cycle),      |
// |               blink (registered phase flag)                                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module watch_half_tick_gen
   import watch_pkg::*;
#(
   parameter int P_COUNT_BIT = DEF_COUNT_BIT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [P_COUNT_BIT-1:0] freq,
   input  logic                   clear,
   output logic                   tick,
   output logic                   blink
);

   logic [P_COUNT_BIT-1:0] half;
   logic [P_COUNT_BIT-1:0] cnt;

   assign half = freq >> 1;

   // ">=" rather than "==" so a smaller freq arriving mid-count wraps on the
   // very next cycle instead of running the counter all the way round.
   assign tick = (half == '0) || (cnt >= half - P_COUNT_BIT'(1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt   <= '0;
         blink <= 1'b0;
      end else if (clear) begin
         cnt   <= '0;
         blink <= 1'b0;
      end else if (tick) begin
         cnt   <= '0;
         blink <= ~blink;
      end else begin
         cnt   <= cnt + P_COUNT_BIT'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/watch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : watch_ctrl                                                   |
// | Description : Mode/setting controller for the watch datapath. Runs/stops  |
// |               the clock, lets the user edit hour/min/sec and issues a     |
// |               one-cycle load strobe with the edited time.                 |
// | Ports       : clk, reset (sync, active-low), i_freq (clk rate in Hz),      |
// |               i_btn_start/mode/up/down (single-cycle pulses),             |
// |               i_hour/i_min/i_sec (current time), o_run_en, o_load,        |
// |               o_load_hour/min/sec, o_edit_sel, o_blink                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module watch_ctrl
   import watch_pkg::*;
#(
   parameter int P_COUNT_BIT   = DEF_COUNT_BIT,
   parameter int P_SEC_BIT     = DEF_SEC_BIT,
   parameter int P_MIN_BIT     = DEF_MIN_BIT,
   parameter int P_HOUR_BIT    = DEF_HOUR_BIT,
   parameter int P_TIMEOUT_SEC = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [P_COUNT_BIT-1:0] i_freq,
   input  logic                   i_btn_start,
   input  logic                   i_btn_mode,
   input  logic                   i_btn_up,
   input  logic                   i_btn_down,
   input  logic [P_SEC_BIT-1:0]   i_sec,
   input  logic [P_MIN_BIT-1:0]   i_min,
   input  logic [P_HOUR_BIT-1:0]  i_hour,
   output logic                   o_run_en,
   output logic                   o_load,
   output logic [P_SEC_BIT-1:0]   o_load_sec,
   output logic [P_MIN_BIT-1:0]   o_load_min,
   output logic [P_HOUR_BIT-1:0]  o_load_hour,
   output logic [1:0]             o_edit_sel,
   output logic                   o_blink
);

   // Two half-ticks per second; 7 bits covers the 1..63 s range.
   localparam int         TO_TICKS = 2 * P_TIMEOUT_SEC;
   localparam logic [6:0] TO_LAST  = 7'(TO_TICKS - 1);

   state_t                state, state_nxt;
   logic [P_HOUR_BIT-1:0] edit_hour, hour_nxt;
   logic [P_MIN_BIT-1:0]  edit_min, min_nxt;
   logic [P_SEC_BIT-1:0]  edit_sec, sec_nxt;
   logic [6:0]            to_cnt;
   logic                  any_btn, cur_edit, nxt_edit;
   logic                  half_tick, timeout_hit, prescale_clr;

   assign any_btn     = i_btn_start | i_btn_mode | i_btn_up | i_btn_down;
   assign cur_edit    = is_edit(state);
   assign nxt_edit    = is_edit(state_nxt);
   assign timeout_hit = cur_edit && !any_btn && half_tick && (to_cnt == TO_LAST);

   // Blink phase restarts on edit entry and on every up/down press; holding
   // it cleared outside edit keeps o_blink at 0 there as a plain register.
   assign prescale_clr = !cur_edit || !nxt_edit || i_btn_up || i_btn_down;

   // The edit registers are the load values; they only matter while o_load=1.
   assign o_load_hour = edit_hour;
   assign o_load_min  = edit_min;
   assign o_load_sec  = edit_sec;

   always_comb begin
      state_nxt = state;
      hour_nxt  = edit_hour;
      min_nxt   = edit_min;
      sec_nxt   = edit_sec;
      case (state)
         ST_STOP, ST_RUN: begin
            if (i_btn_start) begin
               state_nxt = (state == ST_STOP) ? ST_RUN : ST_STOP;
            end else if (i_btn_mode) begin
               state_nxt = ST_EDIT_H;
               hour_nxt  = P_HOUR_BIT'(clamp_field(int'(i_hour), HOURS_PER_DAY));
               min_nxt   = P_MIN_BIT'(clamp_field(int'(i_min), MIN_PER_HOUR));
               sec_nxt   = P_SEC_BIT'(clamp_field(int'(i_sec), SEC_PER_MIN));
            end
         end
         ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
            if (i_btn_start) begin
               state_nxt = ST_STOP;
            end else if (i_btn_mode) begin
               state_nxt = (state == ST_EDIT_H) ? ST_EDIT_M :
                           (state == ST_EDIT_M) ? ST_EDIT_S : ST_COMMIT;
            end else if (i_btn_up ^ i_btn_down) begin
               if (state == ST_EDIT_H) begin
                  hour_nxt = P_HOUR_BIT'(step_field(int'(edit_hour), HOURS_PER_DAY, i_btn_up));
               end else if (state == ST_EDIT_M) begin
                  min_nxt = P_MIN_BIT'(step_field(int'(edit_min), MIN_PER_HOUR, i_btn_up));
               end else begin
                  sec_nxt = P_SEC_BIT'(step_field(int'(edit_sec), SEC_PER_MIN, i_btn_up));
               end
            end else if (timeout_hit) begin
               state_nxt = ST_STOP;
            end
         end
         default: begin
            // COMMIT is a single-cycle state regardless of buttons.
            state_nxt = ST_STOP;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ST_STOP;
         edit_hour  <= '0;
         edit_min   <= '0;
         edit_sec   <= '0;
         to_cnt     <= '0;
         o_run_en   <= 1'b0;
         o_load     <= 1'b0;
         o_edit_sel <= SEL_NONE;
      end else begin
         state     <= state_nxt;
         edit_hour <= hour_nxt;
         edit_min  <= min_nxt;
         edit_sec  <= sec_nxt;
         if (!cur_edit || any_btn) begin
            to_cnt <= '0;
         end else if (half_tick) begin
            to_cnt <= to_cnt + 7'd1;
         end
         // Outputs decode the next state so they line up with the state change.
         o_run_en   <= (state_nxt == ST_RUN);
         o_load     <= (state_nxt == ST_COMMIT);
         o_edit_sel <= edit_sel_of(state_nxt);
      end
   end

   watch_half_tick_gen #(
      .P_COUNT_BIT (P_COUNT_BIT)
   ) u_half_tick (
      .clk   (clk),
      .reset (reset),
      .freq  (i_freq),
      .clear (prescale_clr),
      .tick  (half_tick),
      .blink (o_blink)
   );

endmodule
`default_nettype wire

// File: tb/tb_watch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_watch_ctrl                                                |
// | Description : Self-checking bench for watch_ctrl: directed scenarios plus  |
// |               a randomized run, all compared against a behavioural model. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_watch_ctrl;

   localparam int T_SEC = 2;

   logic        clk;
   logic        reset;
   logic [29:0] i_freq;
   logic        i_btn_start, i_btn_mode, i_btn_up, i_btn_down;
   logic [5:0]  i_sec, i_min;
   logic [4:0]  i_hour;
   logic        o_run_en, o_load, o_blink;
   logic [5:0]  o_load_sec, o_load_min;
   logic [4:0]  o_load_hour;
   logic [1:0]  o_edit_sel;

   int tests = 0;
   int fails = 0;

   // Model: 0 STOP, 1 RUN, 2 EDIT hour, 3 EDIT min, 4 EDIT sec, 5 COMMIT
   int m_st = 0;
   int m_f[3] = '{0, 0, 0};   // hour, min, sec
   int m_age = 0;             // cycles since blink phase restart
   int m_to  = 0;             // half-ticks since last button / entry

   watch_ctrl #(
      .P_COUNT_BIT   (30),
      .P_SEC_BIT     (6),
      .P_MIN_BIT     (6),
      .P_HOUR_BIT    (5),
      .P_TIMEOUT_SEC (T_SEC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .i_freq      (i_freq),
      .i_btn_start (i_btn_start),
      .i_btn_mode  (i_btn_mode),
      .i_btn_up    (i_btn_up),
      .i_btn_down  (i_btn_down),
      .i_sec       (i_sec),
      .i_min       (i_min),
      .i_hour      (i_hour),
      .o_run_en    (o_run_en),
      .o_load      (o_load),
      .o_load_sec  (o_load_sec),
      .o_load_min  (o_load_min),
      .o_load_hour (o_load_hour),
      .o_edit_sel  (o_edit_sel),
      .o_blink     (o_blink)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int period_of(input logic [29:0] f);
      int p;
      p = int'(f >> 1);
      return (p == 0) ? 1 : p;
   endfunction

   function automatic int mod_step(input int v, input int m, input bit up);
      return up ? (v + 1) % m : (v + m - 1) % m;
   endfunction

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_edge();
      int  per, nst;
      bit  ed, nxt_ed, tk, any;
      if (!reset) begin
         m_st = 0; m_f = '{0, 0, 0}; m_age = 0; m_to = 0;
         return;
      end
      per = period_of(i_freq);
      ed  = (m_st >= 2 && m_st <= 4);
      any = i_btn_start | i_btn_mode | i_btn_up | i_btn_down;
      tk  = ed && ((m_age + 1) % per == 0);
      nst = m_st;
      if (m_st == 5) begin
         nst = 0;
      end else if (!ed) begin
         if (i_btn_start) nst = (m_st == 0) ? 1 : 0;
         else if (i_btn_mode) begin
            nst = 2;
            m_f[0] = (int'(i_hour) > 23) ? 0 : int'(i_hour);
            m_f[1] = (int'(i_min) > 59) ? 0 : int'(i_min);
            m_f[2] = (int'(i_sec) > 59) ? 0 : int'(i_sec);
         end
      end else if (i_btn_start) nst = 0;
      else if (i_btn_mode) nst = (m_st == 4) ? 5 : m_st + 1;
      else if (i_btn_up != i_btn_down)
         m_f[m_st-2] = mod_step(m_f[m_st-2], (m_st == 2) ? 24 : 60, i_btn_up);
      else if (!any && tk && (m_to + 1 == 2 * T_SEC)) nst = 0;
      nxt_ed = (nst >= 2 && nst <= 4);
      if (!ed || !nxt_ed || i_btn_up || i_btn_down) m_age = 0;
      else m_age++;
      if (!ed || any) m_to = 0;
      else if (tk) m_to++;
      m_st = nst;
   endtask

   task automatic check_model(input string tag);
      bit ed;
      int eb;
      ed = (m_st >= 2 && m_st <= 4);
      eb = ed ? (m_age / period_of(i_freq)) % 2 : 0;
      chk({tag, ".run_en"},   32'(o_run_en),   32'(m_st == 1));
      chk({tag, ".load"},     32'(o_load),     32'(m_st == 5));
      chk({tag, ".edit_sel"}, 32'(o_edit_sel), ed ? m_st - 1 : 0);
      chk({tag, ".blink"},    32'(o_blink),    eb);
      if (m_st == 5) begin
         chk({tag, ".load_hour"}, 32'(o_load_hour), m_f[0]);
         chk({tag, ".load_min"},  32'(o_load_min),  m_f[1]);
         chk({tag, ".load_sec"},  32'(o_load_sec),  m_f[2]);
      end
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_model(tag);
   endtask

   task automatic press(input string tag, input bit s, input bit m, input bit u, input bit d);
      i_btn_start = s; i_btn_mode = m; i_btn_up = u; i_btn_down = d;
      cycle(tag);
      i_btn_start = 1'b0; i_btn_mode = 1'b0; i_btn_up = 1'b0; i_btn_down = 1'b0;
   endtask

   initial begin
      // Reset with every button held high
      reset = 1'b0; i_freq = 30'd1000;
      i_btn_start = 1'b1; i_btn_mode = 1'b1; i_btn_up = 1'b1; i_btn_down = 1'b1;
      i_hour = 5'd7; i_min = 6'd8; i_sec = 6'd9;
      for (int i = 0; i < 3; i++) cycle("rst");
      chk("rst.run_en",   32'(o_run_en),   0);
      chk("rst.load",     32'(o_load),     0);
      chk("rst.edit_sel", 32'(o_edit_sel), 0);
      chk("rst.blink",    32'(o_blink),    0);
      chk("rst.load_hour", 32'(o_load_hour), 0);
      reset = 1'b1;
      i_btn_start = 1'b0; i_btn_mode = 1'b0; i_btn_up = 1'b0; i_btn_down = 1'b0;
      cycle("idle");
      press("start", 1, 0, 0, 0);
      chk("start.run_en", 32'(o_run_en), 1);

      // Full edit sequence with wrap-arounds
      i_hour = 5'd23; i_min = 6'd59; i_sec = 6'd58;
      press("mode_run", 0, 1, 0, 0);
      chk("edit.run_en", 32'(o_run_en), 0);
      chk("edit.sel_h",  32'(o_edit_sel), 1);
      press("hour_up", 0, 0, 1, 0);
      press("to_min", 0, 1, 0, 0);
      for (int i = 0; i < 60; i++) press("min_down", 0, 0, 0, 1);
      press("to_sec", 0, 1, 0, 0);
      chk("edit.sel_s", 32'(o_edit_sel), 3);
      press("sec_up", 0, 0, 1, 0);
      press("sec_up", 0, 0, 1, 0);
      press("commit", 0, 1, 0, 0);
      chk("commit.load", 32'(o_load), 1);
      chk("commit.hour", 32'(o_load_hour), 0);
      chk("commit.min",  32'(o_load_min), 59);
      chk("commit.sec",  32'(o_load_sec), 0);
      cycle("after_commit");
      chk("after_commit.load", 32'(o_load), 0);

      // Simultaneous buttons in EDIT_M
      i_hour = 5'd5; i_min = 6'd0; i_sec = 6'd7;
      press("sim_mode", 0, 1, 0, 0);
      press("sim_mode", 0, 1, 0, 0);
      press("sim_updown", 0, 0, 1, 1);
      press("sim_modeup", 0, 1, 1, 0);
      chk("sim_modeup.sel", 32'(o_edit_sel), 3);
      press("sim_commit", 0, 1, 0, 0);
      chk("sim_commit.min", 32'(o_load_min), 0);
      cycle("sim_idle");
      press("sim_mode", 0, 1, 0, 0);
      press("sim_mode", 0, 1, 0, 0);
      press("sim_startmode", 1, 1, 0, 0);
      chk("abort.sel",  32'(o_edit_sel), 0);
      chk("abort.load", 32'(o_load), 0);
      cycle("abort_idle");
      chk("abort_idle.load", 32'(o_load), 0);

      // Blink phase at freq=10, phase restart on up, then freq=1
      i_freq = 30'd10;
      press("blink_entry", 0, 1, 0, 0);
      for (int k = 1; k <= 7; k++) begin
         cycle("blink");
         chk("blink.f10", 32'(o_blink), (k / 5) % 2);
      end
      press("blink_up", 0, 0, 1, 0);
      chk("blink_up.phase", 32'(o_blink), 0);
      for (int k = 1; k <= 6; k++) begin
         cycle("blink2");
         chk("blink2.f10", 32'(o_blink), (k / 5) % 2);
      end
      i_freq = 30'd1;
      press("blink_f1_up", 0, 0, 1, 0);
      for (int k = 1; k <= 3; k++) begin
         cycle("blink_f1");
         chk("blink.f1", 32'(o_blink), k % 2);
      end
      cycle("f1_timeout");
      chk("f1_timeout.sel", 32'(o_edit_sel), 0);

      // Inactivity timeout: 2*T_SEC half-ticks of 5 cycles
      i_freq = 30'd10;
      press("to_entry", 0, 1, 0, 0);
      for (int k = 1; k <= 19; k++) begin
         cycle("to_wait");
         chk("to_wait.sel", 32'(o_edit_sel), 1);
      end
      cycle("to_fire");
      chk("to_fire.sel",  32'(o_edit_sel), 0);
      chk("to_fire.load", 32'(o_load), 0);

      // Reset during COMMIT
      i_freq = 30'd1000; i_hour = 5'd3; i_min = 6'd4; i_sec = 6'd5;
      for (int i = 0; i < 4; i++) press("rc_mode", 0, 1, 0, 0);
      chk("rc.load", 32'(o_load), 1);
      chk("rc.sec",  32'(o_load_sec), 5);
      reset = 1'b0;
      cycle("rc_reset");
      chk("rc_reset.load", 32'(o_load), 0);
      chk("rc_reset.hour", 32'(o_load_hour), 0);
      chk("rc_reset.min",  32'(o_load_min), 0);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle("rc_after");
         chk("rc_after.load", 32'(o_load), 0);
      end

      // Reset in EDIT_S
      for (int i = 0; i < 3; i++) press("rs_mode", 0, 1, 0, 0);
      press("rs_up", 0, 0, 1, 0);
      reset = 1'b0;
      cycle("rs_reset");
      chk("rs_reset.sel", 32'(o_edit_sel), 0);
      chk("rs_reset.sec", 32'(o_load_sec), 0);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle("rs_after");
         chk("rs_after.load", 32'(o_load), 0);
      end

      // Randomized run; freq only changes outside edit
      for (int n = 0; n < 1500; n++) begin
         reset       = ($urandom_range(0, 199) != 0);
         i_btn_start = ($urandom_range(0, 11) == 0);
         i_btn_mode  = ($urandom_range(0, 5) == 0);
         i_btn_up    = ($urandom_range(0, 6) == 0);
         i_btn_down  = ($urandom_range(0, 6) == 0);
         i_hour      = 5'($urandom_range(0, 31));
         i_min       = 6'($urandom_range(0, 63));
         i_sec       = 6'($urandom_range(0, 63));
         if (m_st < 2 && $urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 5))
               0: i_freq = 30'd0;
               1: i_freq = 30'd1;
               2: i_freq = 30'd3;
               3: i_freq = 30'd6;
               4: i_freq = 30'd10;
               default: i_freq = 30'd20;
            endcase
         end
         cycle("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
